// File: rtl/bus_grant_arbiter_if.sv
// bus_grant_arbiter_if
//   Three-wire 68k bus arbitration signals shared by the requesters and the arbiter.
//   _BR     per-requester bus request, active low (requesters -> arbiter)
//   _BGACK  wired bus-grant-acknowledge, active low (requesters -> arbiter)
//   _AS     address strobe of the current master, active low (requesters -> arbiter)
//   _BG     per-requester bus grant, active low, one-hot (arbiter -> requesters)
//   Modports: master = requester side, slave = arbiter side.
interface bus_grant_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] _BR;
    logic            _BGACK;
    logic            _AS;
    logic [NREQ-1:0] _BG;

    modport master (
        output _BR,
        output _BGACK,
        output _AS,
        input  _BG
    );

    modport slave (
        input  _BR,
        input  _BGACK,
        input  _AS,
        output _BG
    );
endinterface

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter
//   Granting end of the 68k BR/BG/BGACK arbitration for the expansion bus. Round-robin
//   among NREQ requesters, one-hot active-low grants, ownership tracked through _BGACK,
//   unacknowledged grants withdrawn after GRANT_TIMEOUT cycles.
//   Ports:
//     CLOCK    system clock, posedge
//     RST      synchronous reset, active high
//     ENABLE   1 = new grants allowed; current tenure always completes
//     bus      arbitration interface (slave side): _BR, _BGACK, _AS in; _BG out
//     OWNER    index of granted/owning requester (valid when STATE != IDLE)
//     BUSY     1 while OWNED
//     TIMEOUT  one-cycle pulse when an unacknowledged grant is withdrawn
//     STATE    current state (IDLE=0, GRANT=1, OWNED=2, RELEASE=3)
//   Build option: define ARB_INPUT_SYNC_EN to pass _BR/_BGACK/_AS through 2-flop
//   synchronisers (reset to 1) before use; adds 2 cycles to every input-driven latency.
module bus_grant_arbiter #(
    parameter int NREQ          = 2,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                   CLOCK,
    input  logic                   RST,
    input  logic                   ENABLE,
    bus_grant_arbiter_if.slave     bus,
    output logic [2:0]             OWNER,
    output logic                   BUSY,
    output logic                   TIMEOUT,
    output logic [1:0]             STATE
);
    localparam int unsigned N       = NREQ;
    localparam logic [7:0]  TO_LAST = 8'(GRANT_TIMEOUT - 1);
    localparam logic [2:0]  LAST    = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] bg_q, bg_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [NREQ-1:0] br_s;
    logic            bgack_s;
    logic            as_s;

`ifdef ARB_INPUT_SYNC_EN
    logic [NREQ-1:0] br_s1_q, br_s2_q;
    logic            bgack_s1_q, bgack_s2_q;
    logic            as_s1_q, as_s2_q;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            br_s1_q    <= '1;
            br_s2_q    <= '1;
            bgack_s1_q <= 1'b1;
            bgack_s2_q <= 1'b1;
            as_s1_q    <= 1'b1;
            as_s2_q    <= 1'b1;
        end else begin
            br_s1_q    <= bus._BR;
            br_s2_q    <= br_s1_q;
            bgack_s1_q <= bus._BGACK;
            bgack_s2_q <= bgack_s1_q;
            as_s1_q    <= bus._AS;
            as_s2_q    <= as_s1_q;
        end
    end

    assign br_s    = br_s2_q;
    assign bgack_s = bgack_s2_q;
    assign as_s    = as_s2_q;
`else
    assign br_s    = bus._BR;
    assign bgack_s = bus._BGACK;
    assign as_s    = bus._AS;
`endif

    // Round-robin scan: first low request at or above rr_ptr, wrapping to 0.
    logic       found;
    logic [2:0] win;
    logic       own_br;
    logic [2:0] next_ptr;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && (j == ((32'(rr_ptr_q) + k) % N)) && !br_s[j]) begin
                    found = 1'b1;
                    win   = 3'(j);
                end
            end
        end
        own_br = 1'b1;
        for (int unsigned j = 0; j < N; j++) begin
            if (3'(j) == owner_q) own_br = br_s[j];
        end
        next_ptr = (owner_q == LAST) ? '0 : owner_q + 3'd1;
    end

    always_comb begin
        state_d   = state_q;
        bg_d      = '1;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A low _BGACK here belongs to a foreign owner: grant nothing.
                if (ENABLE && found && bgack_s) begin
                    state_d = GRANT;
                    owner_d = win;
                    cnt_d   = '0;
                    for (int unsigned j = 0; j < N; j++) begin
                        if (3'(j) == win) bg_d[j] = 1'b0;
                    end
                end
            end
            GRANT: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (!bgack_s) begin
                    state_d = OWNED;
                    busy_d  = 1'b1;
                end else if (own_br) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                end else begin
                    for (int unsigned j = 0; j < N; j++) begin
                        if (3'(j) == owner_q) bg_d[j] = 1'b0;
                    end
                end
            end
            OWNED: begin
                if (bgack_s) begin
                    state_d  = RELEASE;
                    rr_ptr_d = next_ptr;
                end else begin
                    busy_d = 1'b1;
                end
            end
            RELEASE: begin
                if (as_s && bgack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_q   <= IDLE;
            bg_q      <= '1;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bg_q      <= bg_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus._BG = bg_q;
    assign OWNER   = owner_q;
    assign BUSY    = busy_q;
    assign TIMEOUT = timeout_q;
    assign STATE   = state_q;
endmodule

// File: tb/tb_bus_grant_arbiter.sv
module tb_bus_grant_arbiter;
`ifdef ARB_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       CLOCK;
    logic       RST;
    logic       ENABLE;
    logic [2:0] OWNER;
    logic       BUSY;
    logic       TIMEOUT;
    logic [1:0] STATE;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    bus_grant_arbiter_if #(.NREQ(2)) bus ();

    bus_grant_arbiter #(.NREQ(2), .GRANT_TIMEOUT(64)) dut (
        .CLOCK   (CLOCK),
        .RST     (RST),
        .ENABLE  (ENABLE),
        .bus     (bus),
        .OWNER   (OWNER),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT),
        .STATE   (STATE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Grant invariants checked every cycle once reset has been applied.
    always @(negedge CLOCK) begin
        if (checking) begin
            total++;
            if ((!bus._BG[0] && !bus._BG[1]) || (STATE != 2'd1 && bus._BG !== 2'b11)) begin
                bad++;
                $display("FAIL invariant_bg got _BG=%b STATE=%0d required one-hot-low only in GRANT",
                         bus._BG, STATE);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        ENABLE     = 1'b1;
        bus._BR    = 2'b11;
        bus._BGACK = 1'b1;
        bus._AS    = 1'b1;
        tick(1);
        RST = 1'b0;
        checking = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus._BG !== 2'b11 || OWNER !== 3'd0 || BUSY !== 1'b0 || TIMEOUT !== 1'b0 || STATE !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got _BG=%b OWNER=%0d BUSY=%b TIMEOUT=%b STATE=%0d required 11 0 0 0 0",
                     bus._BG, OWNER, BUSY, TIMEOUT, STATE);
        end
    endtask

    task automatic test_grant_ack();
        do_reset();
        bus._BR = 2'b10;
        tick(LAT);
        total++;
        if (bus._BG !== 2'b10 || STATE !== 2'd1 || OWNER !== 3'd0) begin
            bad++;
            $display("FAIL grant_req0 got _BG=%b STATE=%0d OWNER=%0d required 10 1 0", bus._BG, STATE, OWNER);
        end
        bus._BGACK = 1'b0;
        tick(LAT);
        total++;
        if (bus._BG !== 2'b11 || BUSY !== 1'b1 || STATE !== 2'd2) begin
            bad++;
            $display("FAIL ack_owned got _BG=%b BUSY=%b STATE=%0d required 11 1 2", bus._BG, BUSY, STATE);
        end
        bus._BGACK = 1'b1;
        bus._BR    = 2'b11;
        tick(LAT);
        total++;
        if (BUSY !== 1'b0 || STATE !== 2'd3) begin
            bad++;
            $display("FAIL owned_release got BUSY=%b STATE=%0d required 0 3", BUSY, STATE);
        end
        tick(1);
        total++;
        if (STATE !== 2'd0) begin
            bad++;
            $display("FAIL release_idle got STATE=%0d required 0", STATE);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus._BR = 2'b00;
        tick(LAT);
        total++;
        if (bus._BG !== 2'b10 || OWNER !== 3'd0) begin
            bad++;
            $display("FAIL rr_first got _BG=%b OWNER=%0d required 10 0", bus._BG, OWNER);
        end
        bus._BGACK = 1'b0;
        tick(LAT);
        bus._BGACK = 1'b1;
        tick(LAT);
        total++;
        if (STATE !== 2'd3) begin
            bad++;
            $display("FAIL rr_release got STATE=%0d required 3", STATE);
        end
        tick(2);
        total++;
        if (bus._BG !== 2'b01 || OWNER !== 3'd1 || STATE !== 2'd1) begin
            bad++;
            $display("FAIL rr_second got _BG=%b OWNER=%0d STATE=%0d required 01 1 1", bus._BG, OWNER, STATE);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus._BR = 2'b00;
        tick(LAT);
        tick(63);
        total++;
        if (bus._BG !== 2'b10 || TIMEOUT !== 1'b0 || STATE !== 2'd1) begin
            bad++;
            $display("FAIL to_before got _BG=%b TIMEOUT=%b STATE=%0d required 10 0 1", bus._BG, TIMEOUT, STATE);
        end
        tick(1);
        total++;
        if (bus._BG !== 2'b11 || TIMEOUT !== 1'b1 || STATE !== 2'd3) begin
            bad++;
            $display("FAIL to_fire got _BG=%b TIMEOUT=%b STATE=%0d required 11 1 3", bus._BG, TIMEOUT, STATE);
        end
        tick(1);
        total++;
        if (TIMEOUT !== 1'b0 || STATE !== 2'd0) begin
            bad++;
            $display("FAIL to_pulse_end got TIMEOUT=%b STATE=%0d required 0 0", TIMEOUT, STATE);
        end
        tick(1);
        total++;
        if (bus._BG !== 2'b01 || OWNER !== 3'd1) begin
            bad++;
            $display("FAIL to_next_req got _BG=%b OWNER=%0d required 01 1", bus._BG, OWNER);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        bus._BR = 2'b10;
        tick(LAT);
        bus._BR = 2'b11;
        tick(LAT);
        total++;
        if (STATE !== 2'd0 || bus._BG !== 2'b11 || TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL withdraw got STATE=%0d _BG=%b TIMEOUT=%b required 0 11 0", STATE, bus._BG, TIMEOUT);
        end
    endtask

    task automatic test_release_as();
        do_reset();
        bus._BR = 2'b10;
        tick(LAT);
        bus._BGACK = 1'b0;
        bus._AS    = 1'b0;
        tick(LAT);
        bus._BGACK = 1'b1;
        bus._BR    = 2'b11;
        tick(LAT);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (STATE !== 2'd3) begin
                bad++;
                $display("FAIL release_hold_%0d got STATE=%0d required 3", i, STATE);
            end
            tick(1);
        end
        bus._AS = 1'b1;
        tick(LAT);
        total++;
        if (STATE !== 2'd0) begin
            bad++;
            $display("FAIL release_as_idle got STATE=%0d required 0", STATE);
        end
    endtask

    task automatic test_enable();
        do_reset();
        ENABLE  = 1'b0;
        bus._BR = 2'b01;
        tick(LAT + 3);
        total++;
        if (STATE !== 2'd0 || bus._BG !== 2'b11) begin
            bad++;
            $display("FAIL enable_off got STATE=%0d _BG=%b required 0 11", STATE, bus._BG);
        end
        ENABLE = 1'b1;
        tick(1);
        total++;
        if (bus._BG !== 2'b01 || OWNER !== 3'd1) begin
            bad++;
            $display("FAIL enable_on got _BG=%b OWNER=%0d required 01 1", bus._BG, OWNER);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus._BR = 2'b10;
        tick(LAT);
        bus._BGACK = 1'b0;
        tick(LAT);
        RST = 1'b1;
        tick(1);
        total++;
        if (bus._BG !== 2'b11 || BUSY !== 1'b0 || STATE !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid got _BG=%b BUSY=%b STATE=%0d required 11 0 0", bus._BG, BUSY, STATE);
        end
        RST = 1'b0;
        tick(LAT + 3);
        total++;
        if (STATE !== 2'd0 || bus._BG !== 2'b11) begin
            bad++;
            $display("FAIL foreign_owner got STATE=%0d _BG=%b required 0 11", STATE, bus._BG);
        end
        bus._BGACK = 1'b1;
        tick(LAT);
        total++;
        if (bus._BG !== 2'b10 || STATE !== 2'd1) begin
            bad++;
            $display("FAIL after_foreign got _BG=%b STATE=%0d required 10 1", bus._BG, STATE);
        end
    endtask

    initial begin
        test_reset();
        test_grant_ack();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_release_as();
        test_enable();
        test_reset_mid();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time limit reached required finish");
        $fatal(1);
    end
endmodule
